// File: rtl/window_extreme_pkg.sv
// Shared encodings and default widths for the windowed extreme-value tracker.
package window_extreme_pkg;

  localparam int unsigned W_DEF     = 32;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

endpackage

// File: rtl/window_extreme_cmp.sv
// Combinational strict compare: replace is high when b strictly beats a
// (greater for max mode, less for min mode), signed or unsigned.
module extreme_cmp
  import window_extreme_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sgn,
  input  logic         mode,
  output logic         replace
);

  logic [W-1:0] a_k;
  logic [W-1:0] b_k;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    a_k     = {a[W-1] ^ sgn, a[W-2:0]};
    b_k     = {b[W-1] ^ sgn, b[W-2:0]};
    replace = (mode == MODE_MIN) ? (b_k < a_k) : (b_k > a_k);
  end

endmodule

// File: rtl/window_extreme.sv
// Windowed max/min tracker: scans len accepted samples and reports the extreme
// value and its in-window index with a one-cycle y_valid pulse.
module window_extreme
  import window_extreme_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             mode,
  input  logic             sgn,
  input  logic             cont,
  input  logic             x_valid,
  input  logic [W-1:0]     x,
  output logic             busy,
  output logic [W-1:0]     y,
  output logic [CNT_W-1:0] y_idx,
  output logic             y_valid
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             mode_q, mode_d;
  logic             sgn_q, sgn_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [W-1:0]     y_q, y_d;
  logic [CNT_W-1:0] y_idx_q, y_idx_d;
  logic             y_valid_q, y_valid_d;
  logic             busy_q, busy_d;

  logic             replace;
  logic [W-1:0]     acc_upd;
  logic [CNT_W-1:0] idx_upd;
  logic             last;

  extreme_cmp #(.W(W)) u_cmp (
    .a       (acc_q),
    .b       (x),
    .sgn     (sgn_q),
    .mode    (mode_q),
    .replace (replace)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      mode_q    <= 1'b0;
      sgn_q     <= 1'b0;
      acc_q     <= '0;
      idx_q     <= '0;
      y_q       <= '0;
      y_idx_q   <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      sgn_q     <= sgn_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      y_q       <= y_d;
      y_idx_q   <= y_idx_d;
      y_valid_q <= y_valid_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    mode_d    = mode_q;
    sgn_d     = sgn_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    y_d       = y_q;
    y_idx_d   = y_idx_q;
    y_valid_d = 1'b0;
    last      = 1'b0;
    acc_upd   = acc_q;
    idx_upd   = idx_q;

    // First sample of a window loads unconditionally; later ones need a strict win.
    if (cnt_q == '0) begin
      acc_upd = x;
      idx_upd = '0;
    end else if (replace) begin
      acc_upd = x;
      idx_upd = cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && (len != '0)) begin
          len_d   = len;
          mode_d  = mode;
          sgn_d   = sgn;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (x_valid) begin
          last = (cnt_q == (len_q - CNT_W'(1)));
          if (last) begin
            y_d       = acc_upd;
            y_idx_d   = idx_upd;
            y_valid_d = 1'b1;
          end
        end
        // A completing window still reports; start then overrides cont.
        if (start) begin
          len_d   = len;
          mode_d  = mode;
          sgn_d   = sgn;
          cnt_d   = '0;
          state_d = (len != '0) ? ST_RUN : ST_IDLE;
        end else if (x_valid) begin
          acc_d = acc_upd;
          idx_d = idx_upd;
          if (last) begin
            cnt_d = '0;
            if (!cont) state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
  end

  assign busy    = busy_q;
  assign y       = y_q;
  assign y_idx   = y_idx_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_window_extreme.sv
// Directed self-checking bench for window_extreme (W=8, CNT_W=16).
module tb_window_extreme;

  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             mode;
  logic             sgn;
  logic             cont;
  logic             x_valid;
  logic [W-1:0]     x;
  logic             busy;
  logic [W-1:0]     y;
  logic [CNT_W-1:0] y_idx;
  logic             y_valid;

  int checks;
  int errors;

  window_extreme #(.W(W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .len     (len),
    .mode    (mode),
    .sgn     (sgn),
    .cont    (cont),
    .x_valid (x_valid),
    .x       (x),
    .busy    (busy),
    .y       (y),
    .y_idx   (y_idx),
    .y_valid (y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [CNT_W-1:0] l, input logic m, input logic s, input logic c);
    start = 1'b1; len = l; mode = m; sgn = s; cont = c; x_valid = 1'b0;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input logic v, input logic [W-1:0] d);
    x_valid = v; x = d;
    step();
    x_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({busy, y, y_idx, y_valid} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%0b y=%0h idx=%0d v=%0b exp all 0", busy, y, y_idx, y_valid);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_unsigned_max();
    go(16'd4, 1'b0, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL umax_busy got %0b exp 1", busy); end
    feed(1'b1, 8'd3);
    feed(1'b1, 8'd9);
    feed(1'b1, 8'd9);
    checks++;
    if (y_valid !== 1'b0) begin errors++; $display("FAIL umax_early_pulse got %0b exp 0", y_valid); end
    feed(1'b1, 8'd2);
    checks++;
    if (y_valid !== 1'b1 || y !== 8'd9 || y_idx !== 16'd1) begin
      errors++; $display("FAIL umax_result got v=%0b y=%0d idx=%0d exp v=1 y=9 idx=1", y_valid, y, y_idx);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL umax_busy_drop got %0b exp 0", busy); end
    step();
    checks++;
    if (y_valid !== 1'b0 || y !== 8'd9 || y_idx !== 16'd1) begin
      errors++; $display("FAIL umax_hold got v=%0b y=%0d idx=%0d exp v=0 y=9 idx=1", y_valid, y, y_idx);
    end
  endtask

  task automatic test_signed_min();
    go(16'd3, 1'b1, 1'b1, 1'b0);
    feed(1'b1, 8'h05);
    feed(1'b1, 8'h80);
    feed(1'b1, 8'h7F);
    checks++;
    if (y_valid !== 1'b1 || y !== 8'h80 || y_idx !== 16'd1) begin
      errors++; $display("FAIL smin_result got v=%0b y=%0h idx=%0d exp v=1 y=80 idx=1", y_valid, y, y_idx);
    end
    go(16'd3, 1'b1, 1'b0, 1'b0);
    feed(1'b1, 8'h05);
    feed(1'b1, 8'h80);
    feed(1'b1, 8'h7F);
    checks++;
    if (y_valid !== 1'b1 || y !== 8'h05 || y_idx !== 16'd0) begin
      errors++; $display("FAIL umin_result got v=%0b y=%0h idx=%0d exp v=1 y=05 idx=0", y_valid, y, y_idx);
    end
  endtask

  task automatic test_gapped();
    go(16'd3, 1'b0, 1'b0, 1'b0);
    feed(1'b1, 8'd4);
    feed(1'b0, 8'hAA);
    feed(1'b0, 8'hBB);
    feed(1'b1, 8'd7);
    feed(1'b0, 8'hCC);
    checks++;
    if (y_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL gap_early got v=%0b busy=%0b exp v=0 busy=1", y_valid, busy);
    end
    feed(1'b1, 8'd1);
    checks++;
    if (y_valid !== 1'b1 || y !== 8'd7 || y_idx !== 16'd1) begin
      errors++; $display("FAIL gap_result got v=%0b y=%0d idx=%0d exp v=1 y=7 idx=1", y_valid, y, y_idx);
    end
  endtask

  task automatic test_continuous();
    logic [W-1:0]     xs [6];
    logic             ev [6];
    logic [W-1:0]     ey [6];
    logic [CNT_W-1:0] ei [6];
    xs = '{8'd1, 8'd5, 8'd8, 8'd2, 8'd0, 8'd0};
    ev = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    ey = '{8'd0, 8'd5, 8'd0, 8'd8, 8'd0, 8'd0};
    ei = '{16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
    go(16'd2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      feed(1'b1, xs[i]);
      checks++;
      if (y_valid !== ev[i] || busy !== 1'b1 || (ev[i] && (y !== ey[i] || y_idx !== ei[i]))) begin
        errors++;
        $display("FAIL cont_%0d got v=%0b busy=%0b y=%0d idx=%0d exp v=%0b busy=1 y=%0d idx=%0d",
                 i, y_valid, busy, y, y_idx, ev[i], ey[i], ei[i]);
      end
    end
    go(16'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b0 || y_valid !== 1'b0) begin
      errors++; $display("FAIL cont_stop got busy=%0b v=%0b exp 0 0", busy, y_valid);
    end
  endtask

  task automatic test_back_to_back();
    go(16'd1, 1'b0, 1'b0, 1'b1);
    feed(1'b1, 8'd7);
    checks++;
    if (y_valid !== 1'b1 || y !== 8'd7 || y_idx !== 16'd0) begin
      errors++; $display("FAIL len1_a got v=%0b y=%0d idx=%0d exp v=1 y=7 idx=0", y_valid, y, y_idx);
    end
    feed(1'b1, 8'd3);
    checks++;
    if (y_valid !== 1'b1 || y !== 8'd3 || y_idx !== 16'd0) begin
      errors++; $display("FAIL len1_b got v=%0b y=%0d idx=%0d exp v=1 y=3 idx=0", y_valid, y, y_idx);
    end
    start = 1'b1; len = 16'd2; mode = 1'b0; sgn = 1'b0; cont = 1'b0;
    feed(1'b1, 8'd5);
    start = 1'b0;
    checks++;
    if (y_valid !== 1'b1 || y !== 8'd5 || busy !== 1'b1) begin
      errors++; $display("FAIL start_at_end got v=%0b y=%0d busy=%0b exp v=1 y=5 busy=1", y_valid, y, busy);
    end
    feed(1'b1, 8'd1);
    feed(1'b1, 8'd4);
    checks++;
    if (y_valid !== 1'b1 || y !== 8'd4 || y_idx !== 16'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL restart_result got v=%0b y=%0d idx=%0d busy=%0b exp 1 4 1 0", y_valid, y, y_idx, busy);
    end
  endtask

  task automatic test_abort();
    go(16'd4, 1'b0, 1'b0, 1'b0);
    feed(1'b1, 8'd9);
    feed(1'b1, 8'd9);
    start = 1'b1; len = 16'd2;
    feed(1'b1, 8'hF0);
    start = 1'b0;
    checks++;
    if (y_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_no_pulse got v=%0b busy=%0b exp v=0 busy=1", y_valid, busy);
    end
    feed(1'b1, 8'd6);
    checks++;
    if (y_valid !== 1'b0) begin errors++; $display("FAIL abort_early got %0b exp 0", y_valid); end
    feed(1'b1, 8'd3);
    checks++;
    if (y_valid !== 1'b1 || y !== 8'd6 || y_idx !== 16'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_result got v=%0b y=%0d idx=%0d busy=%0b exp 1 6 0 0", y_valid, y, y_idx, busy);
    end
    go(16'd0, 1'b0, 1'b0, 1'b0);
    feed(1'b1, 8'd1);
    checks++;
    if (busy !== 1'b0 || y_valid !== 1'b0 || y !== 8'd6) begin
      errors++; $display("FAIL len0_idle got busy=%0b v=%0b y=%0d exp 0 0 6", busy, y_valid, y);
    end
  endtask

  task automatic test_async_reset();
    go(16'd2, 1'b0, 1'b0, 1'b0);
    feed(1'b1, 8'h11);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || y !== 8'h00 || y_idx !== 16'd0 || y_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset got busy=%0b y=%0h idx=%0d v=%0b exp all 0", busy, y, y_idx, y_valid);
    end
    x_valid = 1'b1; x = 8'h22;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (y_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL post_reset_%0d got v=%0b busy=%0b exp 0 0", i, y_valid, busy);
      end
    end
    x_valid = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; start = 1'b0; len = '0; mode = 1'b0; sgn = 1'b0; cont = 1'b0;
    x_valid = 1'b0; x = '0;
    #1;
    test_reset();
    test_unsigned_max();
    test_signed_min();
    test_gapped();
    test_continuous();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
